// File: rtl/chip_switch_seq.sv
// chip_switch_seq: debounces the PAL/NTSC switch and sequences rst_out around the colour-clock mux change.
// Optional macro SWITCH_RUNTIME_EN lets switch changes after boot re-sequence the chip model.

module chip_switch_seq #(
   parameter int DEBOUNCE_BITS = 20,
   parameter int HOLD_CYCLES   = 256,
   parameter int SETTLE_CYCLES = 4096,
   parameter int LOCK_TIMEOUT  = 65535
) (
   input  logic       clk_col4x_pal,
   input  logic       rst,
   input  logic       standard_sw,
   input  logic [1:0] cfg_chip,
   input  logic       cfg_valid,
   input  logic       pll_locked,
   output logic [1:0] chip,
   output logic       chip_mux_sel,
   output logic       rst_out,
   output logic       busy,
   output logic       lock_fail
);

   typedef enum logic [2:0] {
      ST_INIT      = 3'd0,
      ST_HOLD      = 3'd1,
      ST_SWITCH    = 3'd2,
      ST_WAIT_LOCK = 3'd3,
      ST_SETTLE    = 3'd4,
      ST_RUN       = 3'd5
   } state_t;

   localparam int CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES)
      ? ((LOCK_TIMEOUT > HOLD_CYCLES) ? LOCK_TIMEOUT : HOLD_CYCLES)
      : ((SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES);
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_SAT     = '1;
   localparam logic [DEBOUNCE_BITS-1:0] DB_LAST = '1;

   logic                     sw_meta_r, sw_sync_r, lock_meta_r, lock_sync_r;
   logic                     sw_db_r, db_done_r, db_upd_s, sw_evt_s;
   logic [DEBOUNCE_BITS-1:0] db_cnt_r, stable_cnt_r;
   state_t                   state_r, state_nx_s;
   logic [CNT_W-1:0]         cnt_r, cnt_nx_s;
   logic [1:0]               chip_r, chip_nx_s;
   logic                     mux_r, mux_nx_s;
   logic                     lock_fail_r, lock_fail_nx_s;
   logic                     pending_r, pending_nx_s;
   logic                     rst_out_r, busy_r;

   // Two-flop synchronizers for the switch and the PLL lock
   always_ff @(posedge clk_col4x_pal or posedge rst) begin
      if (rst) begin
         sw_meta_r   <= 1'b0;
         sw_sync_r   <= 1'b0;
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
      end else begin
         sw_meta_r   <= standard_sw;
         sw_sync_r   <= sw_meta_r;
         lock_meta_r <= pll_locked;
         lock_sync_r <= lock_meta_r;
      end
   end

   // Accept the new level on the 2^DEBOUNCE_BITS-th consecutive mismatching sample
   assign db_upd_s = (sw_sync_r != sw_db_r) && (db_cnt_r == DB_LAST);

`ifdef SWITCH_RUNTIME_EN
   assign sw_evt_s = db_upd_s;
`else
   assign sw_evt_s = 1'b0;
`endif

   // Debouncer; a stable run with no mismatch also qualifies db_done
   always_ff @(posedge clk_col4x_pal or posedge rst) begin
      if (rst) begin
         sw_db_r      <= 1'b0;
         db_done_r    <= 1'b0;
         db_cnt_r     <= '0;
         stable_cnt_r <= '0;
      end else if (db_upd_s) begin
         sw_db_r      <= sw_sync_r;
         db_done_r    <= 1'b1;
         db_cnt_r     <= '0;
         stable_cnt_r <= '0;
      end else if (sw_sync_r != sw_db_r) begin
         db_cnt_r     <= db_cnt_r + DEBOUNCE_BITS'(1);
         stable_cnt_r <= '0;
      end else begin
         db_cnt_r <= '0;
         if (stable_cnt_r == DB_LAST) begin
            db_done_r <= 1'b1;
         end else begin
            stable_cnt_r <= stable_cnt_r + DEBOUNCE_BITS'(1);
         end
      end
   end

   // Sequencer next-state and next-output logic
   always_comb begin
      state_nx_s     = state_r;
      chip_nx_s      = chip_r;
      mux_nx_s       = mux_r;
      lock_fail_nx_s = lock_fail_r;
      pending_nx_s   = pending_r;
      if (sw_evt_s && (state_r != ST_INIT) && (state_r != ST_RUN)) begin
         pending_nx_s = 1'b1;
      end else begin
         pending_nx_s = pending_r;
      end
      case (state_r)
         ST_INIT: begin
            if (cfg_valid && db_done_r) begin
               chip_nx_s  = {cfg_chip[1], cfg_chip[0] ^ sw_db_r};
               state_nx_s = ST_HOLD;
            end else begin
               state_nx_s = ST_INIT;
            end
         end
         ST_HOLD: begin
            if (cnt_r == HOLD_LAST) begin
               state_nx_s = ST_SWITCH;
            end else begin
               state_nx_s = ST_HOLD;
            end
         end
         ST_SWITCH: begin
            mux_nx_s   = chip_r[0];
            state_nx_s = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (lock_sync_r) begin
               state_nx_s = ST_SETTLE;
            end else if (cnt_r == LOCK_LAST) begin
               lock_fail_nx_s = 1'b1;
               state_nx_s     = ST_HOLD;
            end else begin
               state_nx_s = ST_WAIT_LOCK;
            end
         end
         ST_SETTLE: begin
            if (!lock_sync_r) begin
               state_nx_s = ST_WAIT_LOCK;
            end else if (cnt_r == SETTLE_LAST) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_SETTLE;
            end
         end
         ST_RUN: begin
            if (sw_evt_s || pending_r) begin
               chip_nx_s[0] = ~chip_r[0];
               pending_nx_s = 1'b0;
               state_nx_s   = ST_HOLD;
            end else if (!lock_sync_r) begin
               state_nx_s = ST_HOLD;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         default: begin
            state_nx_s = ST_INIT;
         end
      endcase
      // Every state change restarts the shared counter, which saturates otherwise
      if (state_nx_s != state_r) begin
         cnt_nx_s = '0;
      end else if (cnt_r != CNT_SAT) begin
         cnt_nx_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nx_s = cnt_r;
      end
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk_col4x_pal or posedge rst) begin
      if (rst) begin
         state_r     <= ST_INIT;
         cnt_r       <= '0;
         chip_r      <= 2'b00;
         mux_r       <= 1'b0;
         lock_fail_r <= 1'b0;
         pending_r   <= 1'b0;
         rst_out_r   <= 1'b1;
         busy_r      <= 1'b1;
      end else begin
         state_r     <= state_nx_s;
         cnt_r       <= cnt_nx_s;
         chip_r      <= chip_nx_s;
         mux_r       <= mux_nx_s;
         lock_fail_r <= lock_fail_nx_s;
         pending_r   <= pending_nx_s;
         rst_out_r   <= (state_nx_s != ST_RUN);
         busy_r      <= (state_nx_s != ST_RUN);
      end
   end

   assign chip         = chip_r;
   assign chip_mux_sel = mux_r;
   assign rst_out      = rst_out_r;
   assign busy         = busy_r;
   assign lock_fail    = lock_fail_r;

endmodule

// File: tb/tb_chip_switch_seq.sv
// Directed testbench for chip_switch_seq with short debounce/hold/settle/timeout parameters.
// Runtime-switch scenarios are built when SWITCH_RUNTIME_EN is defined, the ignore-switch scenario otherwise.

module tb_chip_switch_seq;

   logic       clk_col4x_pal = 1'b0;
   logic       rst           = 1'b1;
   logic       standard_sw   = 1'b0;
   logic [1:0] cfg_chip      = 2'b00;
   logic       cfg_valid     = 1'b0;
   logic       pll_locked    = 1'b0;
   logic [1:0] chip;
   logic       chip_mux_sel;
   logic       rst_out;
   logic       busy;
   logic       lock_fail;

   int n_vec = 0;
   int n_bad = 0;

   chip_switch_seq #(
      .DEBOUNCE_BITS(4),
      .HOLD_CYCLES(4),
      .SETTLE_CYCLES(8),
      .LOCK_TIMEOUT(32)
   ) dut (
      .clk_col4x_pal(clk_col4x_pal),
      .rst(rst),
      .standard_sw(standard_sw),
      .cfg_chip(cfg_chip),
      .cfg_valid(cfg_valid),
      .pll_locked(pll_locked),
      .chip(chip),
      .chip_mux_sel(chip_mux_sel),
      .rst_out(rst_out),
      .busy(busy),
      .lock_fail(lock_fail)
   );

   always #5 clk_col4x_pal = ~clk_col4x_pal;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_col4x_pal);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(3);
      n_vec++; if (chip !== 2'b00) begin n_bad++; $display("FAIL reset_chip: got %b want 00", chip); end
      n_vec++; if (chip_mux_sel !== 1'b0) begin n_bad++; $display("FAIL reset_mux: got %b want 0", chip_mux_sel); end
      n_vec++; if (rst_out !== 1'b1) begin n_bad++; $display("FAIL reset_rst_out: got %b want 1", rst_out); end
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
      n_vec++; if (lock_fail !== 1'b0) begin n_bad++; $display("FAIL reset_lock_fail: got %b want 0", lock_fail); end
   endtask

   task automatic test_boot;
      int t;
      cfg_chip    = 2'b01;
      cfg_valid   = 1'b1;
      standard_sw = 1'b0;
      pll_locked  = 1'b0;
      rst         = 1'b0;
      t = 0;
      while (chip !== 2'b01 && t < 100) begin tick(1); t++; end
      n_vec++; if (chip !== 2'b01) begin n_bad++; $display("FAIL boot_chip_init: got %b want 01", chip); end
      n_vec++; if (rst_out !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL boot_hold_rst: got rst_out=%b busy=%b want 1 1", rst_out, busy); end
      t = 0;
      while (chip_mux_sel !== 1'b1 && t < 50) begin tick(1); t++; end
      n_vec++; if (t !== 5) begin n_bad++; $display("FAIL boot_mux_latency: got %0d clocks want 5", t); end
      tick(10);
      pll_locked = 1'b1;
      tick(10);
      n_vec++; if (rst_out !== 1'b1) begin n_bad++; $display("FAIL boot_settle_rst_out: got %b want 1", rst_out); end
      tick(1);
      n_vec++; if (rst_out !== 1'b0) begin n_bad++; $display("FAIL boot_run_rst_out: got %b want 0", rst_out); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL boot_run_busy: got %b want 0", busy); end
      n_vec++; if (chip !== 2'b01) begin n_bad++; $display("FAIL boot_run_chip: got %b want 01", chip); end
      n_vec++; if (chip_mux_sel !== 1'b1) begin n_bad++; $display("FAIL boot_run_mux: got %b want 1", chip_mux_sel); end
      n_vec++; if (lock_fail !== 1'b0) begin n_bad++; $display("FAIL boot_lock_fail: got %b want 0", lock_fail); end
   endtask

`ifdef SWITCH_RUNTIME_EN
   task automatic test_bounce;
      int flips;
      logic [1:0] prev;
      flips = 0;
      prev  = chip;
      for (int i = 0; i < 20; i++) begin
         standard_sw = ~standard_sw;
         for (int k = 0; k < 5; k++) begin
            tick(1);
            if (chip !== prev) begin flips++; prev = chip; end
         end
      end
      standard_sw = 1'b1;
      tick(17);
      if (chip !== prev) begin flips++; prev = chip; end
      n_vec++; if (flips !== 0) begin n_bad++; $display("FAIL bounce_early_flip: got %0d flips want 0", flips); end
      n_vec++; if (chip !== 2'b01) begin n_bad++; $display("FAIL bounce_chip_pre: got %b want 01", chip); end
      tick(1);
      n_vec++; if (chip !== 2'b00) begin n_bad++; $display("FAIL bounce_chip_flip: got %b want 00", chip); end
      prev  = chip;
      flips = 0;
      for (int k = 0; k < 60; k++) begin
         tick(1);
         if (chip !== prev) begin flips++; prev = chip; end
      end
      n_vec++; if (flips !== 0) begin n_bad++; $display("FAIL bounce_extra_flip: got %0d flips want 0", flips); end
      n_vec++; if (chip_mux_sel !== 1'b0) begin n_bad++; $display("FAIL bounce_mux: got %b want 0", chip_mux_sel); end
      n_vec++; if (busy !== 1'b0 || rst_out !== 1'b0) begin n_bad++; $display("FAIL bounce_rerun: got busy=%b rst_out=%b want 0 0", busy, rst_out); end
   endtask

   task automatic test_pending;
      int t;
      pll_locked = 1'b0;
      t = 0;
      while (rst_out !== 1'b1 && t < 20) begin tick(1); t++; end
      n_vec++; if (t !== 3) begin n_bad++; $display("FAIL pend_lockdrop_latency: got %0d clocks want 3", t); end
      n_vec++; if (chip !== 2'b00) begin n_bad++; $display("FAIL pend_lockdrop_chip: got %b want 00", chip); end
      standard_sw = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         tick(1);
         if (c == 8) pll_locked = 1'b1;
         if (c == 18) begin
            n_vec++; if (rst_out !== 1'b1 || chip !== 2'b00) begin n_bad++; $display("FAIL pend_settle: got rst_out=%b chip=%b want 1 00", rst_out, chip); end
         end
         if (c == 19) begin
            n_vec++; if (rst_out !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL pend_one_run: got rst_out=%b busy=%b want 0 0", rst_out, busy); end
         end
         if (c == 20) begin
            n_vec++; if (rst_out !== 1'b1 || chip !== 2'b01) begin n_bad++; $display("FAIL pend_service: got rst_out=%b chip=%b want 1 01", rst_out, chip); end
         end
         if (c == 24) begin
            n_vec++; if (chip_mux_sel !== 1'b0) begin n_bad++; $display("FAIL pend_mux_hold: got %b want 0", chip_mux_sel); end
         end
         if (c == 25) begin
            n_vec++; if (chip_mux_sel !== 1'b1) begin n_bad++; $display("FAIL pend_mux_switch: got %b want 1", chip_mux_sel); end
         end
      end
      n_vec++; if (rst_out !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL pend_rerun: got rst_out=%b busy=%b want 0 0", rst_out, busy); end
   endtask
`else
   task automatic test_macro_off;
      standard_sw = 1'b1;
      tick(40);
      n_vec++; if (chip !== 2'b01) begin n_bad++; $display("FAIL off_chip: got %b want 01", chip); end
      n_vec++; if (chip_mux_sel !== 1'b1) begin n_bad++; $display("FAIL off_mux: got %b want 1", chip_mux_sel); end
      n_vec++; if (rst_out !== 1'b0) begin n_bad++; $display("FAIL off_rst_out: got %b want 0", rst_out); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL off_busy: got %b want 0", busy); end
   endtask
`endif

   task automatic test_timeout;
      int   t;
      logic rst_low;
      rst         = 1'b1;
      cfg_chip    = 2'b11;
      cfg_valid   = 1'b1;
      standard_sw = 1'b0;
      pll_locked  = 1'b0;
      tick(3);
      rst = 1'b0;
      t = 0;
      while (chip !== 2'b11 && t < 100) begin tick(1); t++; end
      n_vec++; if (chip !== 2'b11) begin n_bad++; $display("FAIL tmo_chip_init: got %b want 11", chip); end
      t = 0;
      rst_low = 1'b0;
      while (lock_fail !== 1'b1 && t < 100) begin
         tick(1);
         t++;
         if (rst_out !== 1'b1) rst_low = 1'b1;
      end
      n_vec++; if (t !== 37) begin n_bad++; $display("FAIL tmo_latency: got %0d clocks want 37", t); end
      n_vec++; if (chip_mux_sel !== 1'b1) begin n_bad++; $display("FAIL tmo_mux: got %b want 1", chip_mux_sel); end
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (rst_out !== 1'b1) rst_low = 1'b1;
      end
      n_vec++; if (chip !== 2'b11) begin n_bad++; $display("FAIL tmo_chip_kept: got %b want 11", chip); end
      n_vec++; if (lock_fail !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", lock_fail); end
      n_vec++; if (rst_low !== 1'b0) begin n_bad++; $display("FAIL tmo_rst_out_low: got %b want 0", rst_low); end
      #3;
      rst = 1'b1;
      #1;
      n_vec++; if (chip !== 2'b00) begin n_bad++; $display("FAIL abort_chip: got %b want 00", chip); end
      n_vec++; if (chip_mux_sel !== 1'b0) begin n_bad++; $display("FAIL abort_mux: got %b want 0", chip_mux_sel); end
      n_vec++; if (rst_out !== 1'b1) begin n_bad++; $display("FAIL abort_rst_out: got %b want 1", rst_out); end
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy: got %b want 1", busy); end
      n_vec++; if (lock_fail !== 1'b0) begin n_bad++; $display("FAIL abort_lock_fail: got %b want 0", lock_fail); end
   endtask

   initial begin
      test_reset();
      test_boot();
`ifdef SWITCH_RUNTIME_EN
      test_bounce();
      test_pending();
`else
      test_macro_off();
`endif
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/chip_switch_seq.md
CHIP_SWITCH_SEQ -- requirements
Module: chip_switch_seq

Interface
REQ-001 Parameter DEBOUNCE_BITS, 20, width of the switch debounce counter; a new switch level is stable after 2^DEBOUNCE_BITS clocks.
REQ-002 Parameter HOLD_CYCLES, 256, clocks that rst_out is held before the colour-clock mux select changes.
REQ-003 Parameter SETTLE_CYCLES, 4096, clocks after PLL lock before rst_out releases.
REQ-004 Parameter LOCK_TIMEOUT, 65535, maximum clocks spent waiting for PLL lock.
REQ-005 clk_col4x_pal  in  1  free-running PAL colour oscillator; the only clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 standard_sw  in  1  raw video standard toggle switch; asynchronous, bouncing.
REQ-008 cfg_chip  in  2  chip model from persisted configuration; bit0 1=PAL.
REQ-009 cfg_valid  in  1  cfg_chip is valid; level signal.
REQ-010 pll_locked  in  1  dot4x PLL lock from clockgen; asynchronous to this clock.
REQ-011 chip  out  2  active chip model for vicii and clockgen.
REQ-012 chip_mux_sel  out  1  colour-clock BUFGMUX select; 1=PAL, 0=NTSC.
REQ-013 rst_out  out  1  active-high reset to vicii, x2_clockgen and cpu_reset.
REQ-014 busy  out  1  high in every state except RUN.
REQ-015 lock_fail  out  1  sticky; set on any lock timeout.

Function
REQ-016 standard_sw and pll_locked SHALL each pass through a 2-flop synchronizer before use.
REQ-017 Debouncer: sw_db SHALL take the synchronized level once that level has differed from sw_db for 2^DEBOUNCE_BITS consecutive clocks; any mismatch-free sample restarts the count; db_done SHALL set after the first full stable period following reset.
REQ-018 States: INIT, HOLD, SWITCH, WAIT_LOCK, SETTLE, RUN.
REQ-019 INIT: when cfg_valid=1 and db_done=1, chip <= {cfg_chip[1], cfg_chip[0]^sw_db}; go to HOLD. cfg_chip SHALL be sampled only here.
REQ-020 HOLD: rst_out=1; after HOLD_CYCLES clocks go to SWITCH.
REQ-021 SWITCH: one clock; chip_mux_sel <= chip[0]; go to WAIT_LOCK.
REQ-022 WAIT_LOCK: rst_out=1; on synchronized pll_locked=1 go to SETTLE; after LOCK_TIMEOUT clocks without lock, set lock_fail and go to HOLD (retry, chip unchanged).
REQ-023 SETTLE: if pll_locked drops, go to WAIT_LOCK with the timeout counter cleared; after SETTLE_CYCLES clocks of continuous lock, go to RUN.
REQ-024 RUN: rst_out=0 and busy=0, both registered and changing on the clock edge of RUN entry.
REQ-025 In RUN, a sw_db change SHALL set chip[0] <= ~chip[0] and enter HOLD in the same clock.
REQ-026 In RUN, a pll_locked drop SHALL enter HOLD with chip unchanged.
REQ-027 A sw_db change in HOLD/SWITCH/WAIT_LOCK/SETTLE SHALL set a pending flag; it is serviced as in REQ-025 on the first RUN clock, so rst_out deasserts for exactly one clock.
REQ-028 chip_mux_sel SHALL change only in SWITCH, never while rst_out=0.
REQ-029 Counters SHALL saturate at their terminal value, never wrap, and clear on every state entry.

Reset
REQ-030 On rst, asynchronously: state=INIT, chip=2'b00, chip_mux_sel=0, rst_out=1, busy=1, lock_fail=0, pending=0, sw_db=0, db_done=0, all counters=0.
REQ-031 rst asserted mid-sequence SHALL abort immediately to REQ-030 values; lock_fail SHALL be cleared only by rst.

Configuration
REQ-032 Macro SWITCH_RUNTIME_EN. When defined, REQ-025 and REQ-027 apply. When undefined, sw_db is used only in INIT, later switch changes are ignored, and pending stays 0.

Verification
REQ-033 Use DEBOUNCE_BITS=4, HOLD_CYCLES=4, SETTLE_CYCLES=8, LOCK_TIMEOUT=32 for all scenarios.
REQ-034 Boot: cfg_chip=01, sw=0, cfg_valid=1, pll_locked rises 10 clocks after SWITCH -> chip=01, chip_mux_sel=1, rst_out falls 8 clocks after sync lock, busy=0.
REQ-035 Bounce: toggle sw every 5 clocks for 100 clocks, then hold it at 1 -> exactly one chip[0] flip, occurring 16 clocks after the last edge plus sync latency (macro on).
REQ-036 Timeout: pll_locked=0 forever -> lock_fail=1 after 32 WAIT_LOCK clocks, HOLD re-entered, rst_out never 0.
REQ-037 Pending: sw flips during SETTLE -> one-clock RUN, then chip[0] inverted, chip_mux_sel follows in SWITCH.
REQ-038 Macro off: sw flip in RUN -> chip, chip_mux_sel and rst_out unchanged; rst mid-WAIT_LOCK -> all REQ-030 values the same cycle.
